// File: rtl/nios_custom_dma_pkg.sv
// Shared types and helpers for the custom DMA write master.
// Holds the FSM state encoding and the final-word byteenable decode.
package nios_custom_dma_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte lanes of the last word, keyed by length[1:0]; 0 means a full word.
  function automatic logic [3:0] last_be(input logic [1:0] rem);
    case (rem)
      2'd1:    last_be = 4'b0001;
      2'd2:    last_be = 4'b0011;
      2'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/nios_custom_dma_write_master.sv
// Avalon-MM write master: drains a 32-bit valid/ready stream into a slave,
// one word per cycle, honouring waitrequest, abort and a partial last word.
module nios_custom_dma_write_master
  import nios_custom_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ctl_start,
  input  logic [ADDR_W-1:0]   ctl_base_addr,
  input  logic [LEN_W-1:0]    ctl_length,
  input  logic                ctl_abort,
  output logic                ctl_busy,
  output logic                ctl_done,
  output logic                ctl_aborted,
  input  logic [DATA_W-1:0]   st_data,
  input  logic                st_valid,
  output logic                st_ready,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest
);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [LEN_W-2:0]      r_words;
  logic [1:0]            r_rem;
  logic                  r_aborted;
  logic [ADDR_W-1:0]     r_address;
  logic [DATA_W/8-1:0]   r_byteenable;
  logic                  r_write;
  logic [DATA_W-1:0]     r_writedata;

  logic [LEN_W-2:0]      w_len_words;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_exit;
  logic [DATA_W/8-1:0]   w_be;

  // ceil(len/4): whole words plus one more if any bytes remain.
  assign w_len_words = {1'b0, ctl_length[LEN_W-1:2]}
                     + {{(LEN_W-2){1'b0}}, |ctl_length[1:0]};

  assign w_complete = r_write && !avm_waitrequest;
  assign w_ready    = (r_state == XFER) && (r_words != '0) && !ctl_abort
                   && (!r_write || !avm_waitrequest);
  assign w_accept   = w_ready && st_valid;
  assign w_exit     = ((r_words == '0) || ctl_abort) && (!r_write || w_complete);
  assign w_be       = (r_words == (LEN_W-1)'(1)) ? last_be(r_rem) : '1;

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_words      <= '0;
      r_rem        <= '0;
      r_aborted    <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctl_start) begin
            r_addr    <= {ctl_base_addr[ADDR_W-1:2], 2'b00};
            r_words   <= w_len_words;
            r_rem     <= ctl_length[1:0];
            r_aborted <= 1'b0;
            r_state   <= (ctl_length == '0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (w_accept) begin
            r_writedata  <= st_data;
            r_address    <= r_addr;
            r_byteenable <= w_be;
            r_write      <= 1'b1;
            r_addr       <= r_addr + ADDR_W'(BYTES_PER_WORD);
            r_words      <= r_words - (LEN_W-1)'(1);
          end else if (w_complete) begin
            r_write <= 1'b0;
          end
          // Words still owed at exit means abort, not exhaustion, ended it.
          if (w_exit) begin
            r_state   <= DONE;
            r_aborted <= (r_words != '0);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ctl_busy       = (r_state != IDLE);
  assign ctl_done       = (r_state == DONE);
  assign ctl_aborted    = r_aborted;
  assign st_ready       = w_ready;
  assign avm_address    = r_address;
  assign avm_byteenable = r_byteenable;
  assign avm_write      = r_write;
  assign avm_writedata  = r_writedata;

endmodule

// File: doc/nios_custom_dma_write_master.md
Name: nios_custom_dma_write_master

Overview:
- Avalon-MM write master for the custom DMA. It drains a 32-bit valid/ready word stream into a memory-mapped slave, typically the DMA destination on-chip RAM (single-port, 1024x32, byte-enabled, s1).
- A transfer is defined by a byte base address and a byte length, and is handed over with a start pulse.
- The block generates addresses, the final-word byteenable, Avalon waitrequest stalls, abort handling, and a done pulse.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- LEN_W, 16, transfer byte-length width.
- DATA_W, 32, data width; fixed at 32; byteenable width = DATA_W/8.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- ctl_start  in  1  one-cycle start request; honoured only in IDLE.
- ctl_base_addr  in  ADDR_W  byte base address; bits [1:0] ignored (word-aligned).
- ctl_length  in  LEN_W  transfer length in bytes.
- ctl_abort  in  1  level; stops accepting new words.
- ctl_busy  out  1  high in any state other than IDLE.
- ctl_done  out  1  one-cycle pulse at transfer end.
- ctl_aborted  out  1  high with ctl_done if the transfer ended by abort; held until next start.
- st_data  in  32  stream word; byte 0 = bits [7:0] = lowest address.
- st_valid  in  1  stream word valid.
- st_ready  out  1  word accepted on a cycle with st_valid && st_ready.
- avm_address  out  ADDR_W  byte address; always a multiple of 4.
- avm_byteenable  out  4  byte lanes.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset values: ctl_busy=0, ctl_done=0, ctl_aborted=0, st_ready=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0; FSM=IDLE. Reset mid-transfer abandons the transfer immediately, including any held write.
- FSM states: IDLE, XFER, DONE.
  - IDLE: on ctl_start, latch addr=base & ~3, words=ceil(len/4) (LEN_W-1 bit count), rem=len[1:0].
    - If len==0, go to DONE.
    - Otherwise go to XFER.
  - XFER: st_ready = (words_to_accept>0) && !ctl_abort && (!avm_write || !avm_waitrequest). st_ready is combinational from registers plus ctl_abort and avm_waitrequest.
  - Accept: load avm_writedata=st_data, avm_address=addr, avm_byteenable=be, avm_write=1. Then addr+=4 (modulo 2^ADDR_W) and words_to_accept-=1.
  - Word completes when avm_write && !avm_waitrequest. If no new accept occurs in the same cycle, avm_write drops to 0.
  - While avm_waitrequest=1: avm_address, avm_byteenable, avm_writedata and avm_write are held stable (Avalon rule).
  - Leave XFER for DONE when (words_to_accept==0, or ctl_abort) AND no write outstanding (avm_write==0, or completing this cycle).
  - DONE: ctl_done=1 for exactly this cycle; ctl_aborted=1 if abort caused the exit; next state IDLE.
- byteenable: 4'b1111 for all words except the last. Last word by rem: 0->1111, 1->0001, 2->0011, 3->0111.
- Throughput: one word per cycle with waitrequest low. Latency: start at edge N, XFER in N+1; the first avm_write is visible the cycle after the first accept (earliest N+2).
- ctl_start outside IDLE is ignored.
- ctl_abort in IDLE is ignored.
- ctl_abort during a held write never drops that write.

Decomposition:
- Package nios_custom_dma_pkg holds:
  - the FSM state enum (IDLE, XFER, DONE);
  - BYTES_PER_WORD=4;
  - function last_be(rem) returning the last-word byteenable.
- No sub-module; address, count and output registers are a single always_ff.

Test Plan:
- base=0x100, len=16, 4 words streamed back-to-back, waitrequest=0 -> writes at 0x100, 0x104, 0x108, 0x10C, be=1111, in consecutive cycles; ctl_done the cycle after the last write completes; ctl_aborted=0.
- len=6, words A,B -> 2 writes, be=1111 then 0011; st_ready=0 after the 2nd accept.
- waitrequest=1 for 3 cycles on word 2 of 4 -> address, data and be held identical for 4 cycles; st_ready=0 during the stall; all 4 words written in order.
- len=0 -> no avm_write ever; ctl_done one cycle after start; ctl_busy high for exactly 1 cycle.
- ctl_abort asserted while word 3 of 8 is stalled -> word 3 completes; no further st_ready; ctl_done with ctl_aborted=1.
- reset asserted mid-XFER with avm_write=1 -> all outputs reach reset values without a clock edge; a new start after release runs normally from IDLE.
